// File: rtl/seq_det_scheduler.sv
// Round-robin scheduler that time-shares one bit-serial Moore sequence detector.
// Grants a requester, clears the detector, shifts its frame MSB-first and counts hits.
module seq_det_scheduler #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned FRAME_W = 8,
    parameter int unsigned CNT_W   = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*FRAME_W-1:0] frame_data,
    output logic [NREQ-1:0]         gnt,
    output logic                    busy,
    output logic                    det_reset,
    output logic                    det_x,
    input  logic                    det_z,
    output logic                    done,
    output logic [ID_W-1:0]         done_id,
    output logic [CNT_W-1:0]        hit_cnt
);

    localparam int unsigned BW = $clog2(FRAME_W + 1);

    typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, DRAIN, DONE} state_t;

    state_t             state, state_nxt;
    logic [ID_W-1:0]    ptr, ptr_nxt;
    logic [ID_W-1:0]    cur, cur_nxt;
    logic [FRAME_W-1:0] sreg, sreg_nxt;
    logic [BW-1:0]      bcnt, bcnt_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt, cnt_inc;

    logic [NREQ-1:0]    gnt_nxt;
    logic               busy_nxt, det_reset_nxt, det_x_nxt, done_nxt;
    logic [ID_W-1:0]    done_id_nxt;
    logic [CNT_W-1:0]   hit_cnt_nxt;

    logic               found;
    logic [ID_W-1:0]    win, win_inc;
    logic [ID_W:0]      scan;
    logic [FRAME_W-1:0] win_frame;
    logic [NREQ-1:0]    win_onehot;

    // First pending request at or above the rr pointer, wrapping at NREQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        scan  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            scan = {1'b0, ptr} + (ID_W+1)'(i);
            if (scan >= (ID_W+1)'(NREQ))
                scan = scan - (ID_W+1)'(NREQ);
            if (!found && req[scan[ID_W-1:0]]) begin
                found = 1'b1;
                win   = scan[ID_W-1:0];
            end
        end
    end

    always_comb begin
        win_frame  = '0;
        win_onehot = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win == ID_W'(i)) begin
                win_frame     = frame_data[i*FRAME_W +: FRAME_W];
                win_onehot[i] = 1'b1;
            end
        end
        win_inc = (win == ID_W'(NREQ - 1)) ? '0 : win + 1'b1;
    end

    assign cnt_inc = (det_z && cnt != '1) ? cnt + 1'b1 : cnt;

    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        cur_nxt       = cur;
        sreg_nxt      = sreg;
        bcnt_nxt      = bcnt;
        cnt_nxt       = cnt;
        gnt_nxt       = gnt;
        det_reset_nxt = 1'b1;
        det_x_nxt     = 1'b0;
        done_nxt      = 1'b0;
        done_id_nxt   = done_id;
        hit_cnt_nxt   = hit_cnt;

        case (state)
            // DONE arbitrates too, so back-to-back jobs start on the edge after done.
            IDLE, DONE: begin
                if (found) begin
                    state_nxt     = CLEAR;
                    gnt_nxt       = win_onehot;
                    cur_nxt       = win;
                    ptr_nxt       = win_inc;
                    sreg_nxt      = win_frame;
                    cnt_nxt       = '0;
                    det_reset_nxt = 1'b0;
                end else begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                end
            end
            CLEAR: begin
                state_nxt = SHIFT;
                det_x_nxt = sreg[FRAME_W-1];
                sreg_nxt  = sreg << 1;
                bcnt_nxt  = BW'(1);
            end
            SHIFT: begin
                if (bcnt >= BW'(2))
                    cnt_nxt = cnt_inc;
                if (bcnt == BW'(FRAME_W)) begin
                    state_nxt = DRAIN;
                end else begin
                    det_x_nxt = sreg[FRAME_W-1];
                    sreg_nxt  = sreg << 1;
                    bcnt_nxt  = bcnt + 1'b1;
                end
            end
            DRAIN: begin
                state_nxt   = DONE;
                cnt_nxt     = cnt_inc;
                gnt_nxt     = '0;
                done_nxt    = 1'b1;
                done_id_nxt = cur;
                hit_cnt_nxt = cnt_inc;
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ptr       <= '0;
            cur       <= '0;
            sreg      <= '0;
            bcnt      <= '0;
            cnt       <= '0;
            gnt       <= '0;
            busy      <= 1'b0;
            det_reset <= 1'b0;
            det_x     <= 1'b0;
            done      <= 1'b0;
            done_id   <= '0;
            hit_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            cur       <= cur_nxt;
            sreg      <= sreg_nxt;
            bcnt      <= bcnt_nxt;
            cnt       <= cnt_nxt;
            gnt       <= gnt_nxt;
            busy      <= busy_nxt;
            det_reset <= det_reset_nxt;
            det_x     <= det_x_nxt;
            done      <= done_nxt;
            done_id   <= done_id_nxt;
            hit_cnt   <= hit_cnt_nxt;
        end
    end

endmodule
